// File: rtl/k6502_seq.sv
`default_nettype none
// ============================================================================
//  Module      : k6502_seq
//  Description : Instruction sequencer for the k6502 core. Latches the opcode
//                from the bus, steps the one-hot microcycle field that, with
//                the opcode, addresses the microcode ROM, traps runaway or
//                unimplemented opcodes and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module k6502_seq #(
    parameter int          CNT_W    = 16,
    parameter logic [7:0]  RESET_IR = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rdy,
    input  logic [7:0]       di,
    input  logic             next,
    output logic [7:0]       ir,
    output logic [5:0]       cycle,
    output logic             trap,
    output logic [CNT_W-1:0] insn_cnt
);

    // One-hot microcycle encodings; all-zero is the reset/refetch slot.
    localparam logic [5:0] c_CYC_N = 6'b000000;
    localparam logic [5:0] c_CYC_0 = 6'b000001;
    localparam logic [5:0] c_CYC_1 = 6'b000010;
    localparam logic [5:0] c_CYC_2 = 6'b000100;
    localparam logic [5:0] c_CYC_3 = 6'b001000;
    localparam logic [5:0] c_CYC_4 = 6'b010000;
    localparam logic [5:0] c_CYC_5 = 6'b100000;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // What the sequencer does on the coming edge, in priority order.
    typedef enum logic [1:0] {
        A_HOLD  = 2'd0,
        A_FETCH = 2'd1,
        A_TRAP  = 2'd2,
        A_STEP  = 2'd3
    } action_t;

    logic [7:0]       r_ir;
    logic [5:0]       r_cycle;
    logic             r_trap;
    logic [CNT_W-1:0] r_cnt;

    action_t          w_action;
    logic             w_cycle_legal;
    logic [7:0]       w_ir_nxt;
    logic [5:0]       w_cycle_nxt;
    logic             w_trap_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Recognise the seven legal cycle encodings; anything else is corruption.
    always_comb begin
        w_cycle_legal = 1'b0;
        case (r_cycle)
            c_CYC_N, c_CYC_0, c_CYC_1, c_CYC_2,
            c_CYC_3, c_CYC_4, c_CYC_5: w_cycle_legal = 1'b1;
            default:                   w_cycle_legal = 1'b0;
        endcase
    end

    // Choose the edge action and derive next register values from it.
    always_comb begin
        w_action    = A_HOLD;
        w_ir_nxt    = r_ir;
        w_cycle_nxt = r_cycle;
        w_trap_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;

        if (rdy) begin
            if (next) begin
                // A fetch at C_5 is legal, so it outranks the trap check.
                w_action = A_FETCH;
            end else if ((r_cycle == c_CYC_5) || !w_cycle_legal) begin
                w_action = A_TRAP;
            end else begin
                w_action = A_STEP;
            end
        end

        case (w_action)
            A_FETCH: begin
                w_ir_nxt    = di;
                w_cycle_nxt = c_CYC_0;
                // The refetch from the reset slot is not a retired instruction.
                if (r_cycle != c_CYC_N) begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            A_TRAP: begin
                w_ir_nxt    = RESET_IR;
                w_cycle_nxt = c_CYC_N;
                w_trap_nxt  = 1'b1;
            end
            A_STEP: begin
                w_cycle_nxt = (r_cycle == c_CYC_N) ? c_CYC_0 : (r_cycle << 1);
            end
            default: begin
                // Stalled: everything holds, trap pulse drops.
            end
        endcase
    end

    // State registers; reset overrides rdy and discards any instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir    <= RESET_IR;
            r_cycle <= c_CYC_N;
            r_trap  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_ir    <= w_ir_nxt;
            r_cycle <= w_cycle_nxt;
            r_trap  <= w_trap_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign ir       = r_ir;
    assign cycle    = r_cycle;
    assign trap     = r_trap;
    assign insn_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/k6502_seq.md
# k6502_seq

Instruction sequencer for the k6502 core. It latches the opcode from the data bus and steps the one-hot cycle field, and together these two values address the microcode ROM. It consumes the ROM's NEXT bit (last bit of the control word) to end an instruction. It also traps runaway or unimplemented opcodes and counts retired instructions. It sits between the bus data-in register and the microcode ROM: its `ir`/`cycle` outputs drive the ROM and the ROM's `next` feeds back.

## Interface
- `CNT_W`, default 16: width of retired-instruction counter.
- `RESET_IR`, default 8'h00: opcode loaded on reset and on trap; the reset microcode slot.
- `clk` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rdy` in 1: advance enable; 0 freezes all state.
- `di` in 8: bus read data; carries the opcode during the cycle in which `next`=1.
- `next` in 1: NEXT bit of the current control word; 1 = this cycle is the last one of the instruction (opcode fetch of the following instruction).
- `ir` out 8: current opcode, registered.
- `cycle` out 6: current microcycle, registered. Encodings: C_N=6'b000000 (reset/refetch slot), C_0=000001, C_1=000010, C_2=000100, C_3=001000, C_4=010000, C_5=100000.
- `trap` out 1: registered one-cycle pulse, asserted in the cycle after a trap.
- `insn_cnt` out CNT_W: retired-instruction count, registered.

## Operation
- Reset values: `ir`=RESET_IR, `cycle`=C_N, `trap`=0, `insn_cnt`=0.
- Reset takes priority over everything, including `rdy`=0. Reset mid-instruction discards the instruction and does not count it.
- `rdy`=0, no reset: `ir`, `cycle` and `insn_cnt` hold. `trap` clears to 0. `next` and `di` are ignored.
- `rdy`=1, no reset, priority order:
  1. Fetch: if `next`=1, then `ir`<=`di` and `cycle`<=C_0. `insn_cnt` increments (wraps all-ones to 0) only if the current `cycle`≠C_N; the reset slot's fetch is not an instruction.
  2. Trap: else if `cycle`=C_5, or `cycle` is not one of the seven legal encodings, then `ir`<=RESET_IR, `cycle`<=C_N, `trap`<=1, and `insn_cnt` holds. The RESET_IR/C_N control word asserts `next`, so the CPU refetches at PC.
  3. Step: else if `cycle`=C_N, then `cycle`<=C_0. Otherwise `cycle`<=`cycle`<<1. `ir` holds.
- `trap` is 0 on every `rdy`=1 edge that does not take the trap branch.
- Instruction lengths follow from the microcode alone: an instruction whose last microcycle is C_k occupies k+1 clocks, C_0..C_k. The maximum legal length is C_0..C_5 with `next` at C_5. An opcode with no microcode never asserts `next`; it runs C_0..C_5 and then traps.
- `next`=1 at C_5 is a legal fetch, not a trap; branch 1 beats branch 2.

## Timing
- Opcode-to-ROM latency: `di` is sampled on the edge ending a `next`=1 cycle. The new `ir` and C_0 are visible in the following cycle with no combinational path from `di` to `ir`.
- `next` to `cycle` is one edge. No outputs are combinational from inputs.
- After reset release: cycle 0 is C_N; the ROM asserts `next`; the first opcode is latched on that edge and C_0 follows. The first real instruction starts 1 clock after reset deasserts.
- `trap` is high exactly one clock: the C_N cycle after the trap edge, or shorter if `rdy` drops. It is never high on two consecutive `rdy`=1 cycles.
- Back-to-back `next` is legal (a 1-cycle instruction at C_0). `cycle` stays C_0, `ir` reloads, and `insn_cnt` increments every edge.
- Counter wrap: `insn_cnt`=all-ones plus a retire gives 0, with no flag.

## Test plan
- Reset then LDA #imm: after reset, `di`=8'hA9 with `next`=1 at C_N. Expect `ir`=A9 and `cycle`=C_0, with `insn_cnt`=0. Then `next`=0 at C_0 and `next`=1 at C_1 with `di`=8'hEA. Expect `ir`=EA, `cycle`=C_0, `insn_cnt`=1.
- JMP ind length: `ir`=6C with `next` asserted only at C_4. Expect the sequence C_0 through C_4, then C_0 with the new `ir`. `insn_cnt`+1 and `trap` stays 0.
- Unimplemented opcode 8'hFF with `next` held 0. Expect C_0..C_5, then `ir`=00, `cycle`=C_N, `trap`=1 for one clock, `insn_cnt` unchanged. A following `next`=1 with `di`=8'hEA fetches cleanly.
- Stall: `rdy`=0 for 3 clocks at C_2 of 8D, with `next`/`di` toggling. Expect `ir`=8D, `cycle`=C_2 and `insn_cnt` all frozen; the sequence resumes at C_3 when `rdy`=1.
- Reset mid-instruction: assert `reset` at C_3 of AD, with `rdy`=0 and `next`=1. Expect `ir`=00, `cycle`=C_N, `insn_cnt`=0, `trap`=0 on the next clock.
- Wrap/edge: preload `insn_cnt`=16'hFFFF via 65535 one-cycle NOPs with `next`=1 each edge; one more retire gives 0. Also force `next`=1 at C_5: expect a fetch, not a trap.
